ram_sp_arb2: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle read latency, per-bit write mask) between two requesters, A and B.

---
 rtl/ram_sp_arb2_pkg.sv | 22 ++
 rtl/ram_sp_arb2_pick.sv | 23 ++
 rtl/ram_sp_arb2.sv | 172 +++++++++++++++++
 tb/tb_ram_sp_arb2.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_arb2_pkg.sv
// ram_sp_arb2_pkg
//   Shared definitions for the two-port RAM arbiter.
//   - state_t   : arbiter FSM encodings (free arbitration, locked to A, locked to B)
//   - CPortA/B  : requester indices into the 2-bit request/grant vectors
//   - otherPort : the priority value naming the port that is not p
package ram_sp_arb2_pkg;

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_LOCKA = 2'd1,
    S_LOCKB = 2'd2
  } state_t;

  localparam int CPortA = 0;
  localparam int CPortB = 1;

  // Priority is one bit: 0 names port A, 1 names port B.
  function automatic logic otherPort(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/ram_sp_arb2_pick.sv
// arb_rr2_pick
//   Combinational 2-way round-robin picker.
//   Ports:
//     req   in  [1:0]  request vector, bit 0 = port A, bit 1 = port B
//     prio  in  1      port that wins a tie (0 = A, 1 = B)
//     grant out [1:0]  one-hot grant, or 0 when nothing requests
module arb_rr2_pick
  import ram_sp_arb2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = 2'b00;
      grant[prio ? CPortB : CPortA] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_sp_arb2.sv
// ram_sp_arb2
//   Shares one single-port synchronous RAM (1-cycle read latency, per-bit
//   write mask) between requesters A and B. Round-robin arbitration with an
//   optional bounded lock so one port can run a read-modify-write sequence.
//   Grants are combinational: the granted port's command is muxed straight
//   onto the RAM pins in the cycle it is acknowledged.
//   Ports:
//     AClkH, AResetN, AClkHEn    clock, async active-low reset, clock enable
//     AReqX/ALockX               request / keep grant after this access
//     AAddrX/AMosiX/AWrEnX/ARdEnX  access command (address, data, bit mask, read)
//     AAckX                      access accepted this cycle
//     AMisoX/AVldX               read data (0 when not valid) and valid
//     ARamAddr/Mosi/WrEn/RdEn    to RAM wrapper; ARamMiso from RAM
module ram_sp_arb2
  import ram_sp_arb2_pkg::*;
#(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 16,
  parameter int CLockMax = 8
) (
  input  logic                AClkH,
  input  logic                AResetN,
  input  logic                AClkHEn,

  input  logic                AReqA,
  input  logic                ALockA,
  input  logic [CAddrLen-1:0] AAddrA,
  input  logic [CDataLen-1:0] AMosiA,
  input  logic [CDataLen-1:0] AWrEnA,
  input  logic                ARdEnA,
  output logic                AAckA,
  output logic [CDataLen-1:0] AMisoA,
  output logic                AVldA,

  input  logic                AReqB,
  input  logic                ALockB,
  input  logic [CAddrLen-1:0] AAddrB,
  input  logic [CDataLen-1:0] AMosiB,
  input  logic [CDataLen-1:0] AWrEnB,
  input  logic                ARdEnB,
  output logic                AAckB,
  output logic [CDataLen-1:0] AMisoB,
  output logic                AVldB,

  output logic [CAddrLen-1:0] ARamAddr,
  output logic [CDataLen-1:0] ARamMosi,
  output logic [CDataLen-1:0] ARamWrEn,
  output logic                ARamRdEn,
  input  logic [CDataLen-1:0] ARamMiso
);

  localparam int CCntLen = $clog2(CLockMax + 1);

  state_t               fState, nState;
  logic                 fPrio, nPrio;
  logic [CCntLen-1:0]   fLockCnt, nLockCnt;
  logic                 fRdA, fRdB;

  logic [1:0]           req;
  logic [1:0]           pick;
  logic [1:0]           grant;
  logic                 lockLast;

  assign req = {AReqB, AReqA};

  arb_rr2_pick uPick (
    .req   (req),
    .prio  (fPrio),
    .grant (pick)
  );

  // fLockCnt holds the number of accesses already granted in the current
  // locked sequence, so the grant taken while it equals CLockMax-1 is the
  // last one allowed.
  assign lockLast = (fLockCnt >= CCntLen'(CLockMax - 1));

  always_comb begin
    grant    = 2'b00;
    nState   = fState;
    nPrio    = fPrio;
    nLockCnt = fLockCnt;
    case (fState)
      S_ARB: begin
        grant = pick;
        if (grant != 2'b00) begin
          // The tie winner hands priority to the other port.
          if (req == 2'b11)
            nPrio = grant[CPortA] ? 1'(CPortB) : 1'(CPortA);
          // With CLockMax==1 the first grant is already the last, so no lock.
          if ((grant[CPortA] ? ALockA : ALockB) && (CLockMax > 1)) begin
            nState   = grant[CPortA] ? S_LOCKA : S_LOCKB;
            nLockCnt = CCntLen'(1);
          end
        end
      end
      S_LOCKA: begin
        grant[CPortA] = AReqA;
        if (AReqA) begin
          if (!ALockA || lockLast) begin
            nState   = S_ARB;
            nPrio    = otherPort(1'(CPortA));
            nLockCnt = '0;
          end else begin
            nLockCnt = fLockCnt + CCntLen'(1);
          end
        end
      end
      S_LOCKB: begin
        grant[CPortB] = AReqB;
        if (AReqB) begin
          if (!ALockB || lockLast) begin
            nState   = S_ARB;
            nPrio    = otherPort(1'(CPortB));
            nLockCnt = '0;
          end else begin
            nLockCnt = fLockCnt + CCntLen'(1);
          end
        end
      end
      default: begin
        nState   = S_ARB;
        nLockCnt = '0;
      end
    endcase
  end

  always_ff @(posedge AClkH or negedge AResetN) begin
    if (!AResetN) begin
      fState   <= S_ARB;
      fPrio    <= 1'(CPortA);
      fLockCnt <= '0;
      fRdA     <= 1'b0;
      fRdB     <= 1'b0;
    end else if (AClkHEn) begin
      fState   <= nState;
      fPrio    <= nPrio;
      fLockCnt <= nLockCnt;
      fRdA     <= grant[CPortA] & ARdEnA;
      fRdB     <= grant[CPortB] & ARdEnB;
    end
  end

  assign AAckA = grant[CPortA] & AClkHEn;
  assign AAckB = grant[CPortB] & AClkHEn;

  // Strobes are also gated by the enable so a stalled cycle never writes.
  always_comb begin
    ARamAddr = '0;
    ARamMosi = '0;
    ARamWrEn = '0;
    ARamRdEn = 1'b0;
    if (grant[CPortA]) begin
      ARamAddr = AAddrA;
      ARamMosi = AMosiA;
      ARamWrEn = AWrEnA & {CDataLen{AClkHEn}};
      ARamRdEn = ARdEnA & AClkHEn;
    end else if (grant[CPortB]) begin
      ARamAddr = AAddrB;
      ARamMosi = AMosiB;
      ARamWrEn = AWrEnB & {CDataLen{AClkHEn}};
      ARamRdEn = ARdEnB & AClkHEn;
    end
  end

  // The RAM output is stalled by the same enable, so holding fRdX keeps
  // the returned word stable across AClkHEn=0 cycles.
  assign AVldA  = fRdA;
  assign AVldB  = fRdB;
  assign AMisoA = fRdA ? ARamMiso : '0;
  assign AMisoB = fRdB ? ARamMiso : '0;

endmodule

// File: tb/tb_ram_sp_arb2.sv
// tb_ram_sp_arb2
//   Directed bench for ram_sp_arb2 with a behavioural single-port RAM
//   (write-first on masked bits, 1-cycle read latency, stalled by AClkHEn).
module tb_ram_sp_arb2;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LM = 8;

  logic          AClkH = 1'b0;
  logic          AResetN;
  logic          AClkHEn;
  logic          AReqA, ALockA, ARdEnA, AAckA, AVldA;
  logic [AW-1:0] AAddrA;
  logic [DW-1:0] AMosiA, AWrEnA, AMisoA;
  logic          AReqB, ALockB, ARdEnB, AAckB, AVldB;
  logic [AW-1:0] AAddrB;
  logic [DW-1:0] AMosiB, AWrEnB, AMisoB;
  logic [AW-1:0] ARamAddr;
  logic [DW-1:0] ARamMosi, ARamWrEn, ARamMiso;
  logic          ARamRdEn;

  always #5 AClkH = ~AClkH;

  ram_sp_arb2 #(.CAddrLen(AW), .CDataLen(DW), .CLockMax(LM)) dut (
    .AClkH(AClkH), .AResetN(AResetN), .AClkHEn(AClkHEn),
    .AReqA(AReqA), .ALockA(ALockA), .AAddrA(AAddrA), .AMosiA(AMosiA),
    .AWrEnA(AWrEnA), .ARdEnA(ARdEnA), .AAckA(AAckA), .AMisoA(AMisoA), .AVldA(AVldA),
    .AReqB(AReqB), .ALockB(ALockB), .AAddrB(AAddrB), .AMosiB(AMosiB),
    .AWrEnB(AWrEnB), .ARdEnB(ARdEnB), .AAckB(AAckB), .AMisoB(AMisoB), .AVldB(AVldB),
    .ARamAddr(ARamAddr), .ARamMosi(ARamMosi), .ARamWrEn(ARamWrEn),
    .ARamRdEn(ARamRdEn), .ARamMiso(ARamMiso)
  );

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ramQ = '0;

  always @(posedge AClkH) begin
    if (AClkHEn) begin
      if (ARamRdEn)
        ramQ <= (mem[ARamAddr] & ~ARamWrEn) | (ARamMosi & ARamWrEn);
      if (ARamWrEn != '0)
        mem[ARamAddr] <= (mem[ARamAddr] & ~ARamWrEn) | (ARamMosi & ARamWrEn);
    end
  end
  assign ARamMiso = ramQ;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  task automatic setA(input logic r, input logic l, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] w, input logic rd);
    AReqA = r; ALockA = l; AAddrA = a; AMosiA = d; AWrEnA = w; ARdEnA = rd;
  endtask

  task automatic setB(input logic r, input logic l, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] w, input logic rd);
    AReqB = r; ALockB = l; AAddrB = a; AMosiB = d; AWrEnB = w; ARdEnB = rd;
  endtask

  task automatic idle();
    setA(0, 0, '0, '0, '0, 0);
    setB(0, 0, '0, '0, '0, 0);
  endtask

  task automatic doReset();
    AResetN = 1'b0;
    idle();
    tick();
    tick();
    AResetN = 1'b1;
  endtask

  int  bCnt;
  logic gotA;
  logic prevA, prevB;

  initial begin
    AClkHEn = 1'b1;
    AResetN = 1'b0;
    idle();
    tick();
    #1;
    chkEq("rst_vldA",   32'(AVldA), 0);
    chkEq("rst_misoB",  32'(AMisoB), 0);
    chkEq("rst_ackA",   32'(AAckA), 0);
    chkEq("rst_ramWr",  32'(ARamWrEn), 0);
    chkEq("rst_ramAd",  32'(ARamAddr), 0);
    tick();
    AResetN = 1'b1;

    // Write, then read back on the next cycle.
    tick();
    setA(1, 0, 8'h10, 16'hBEEF, 16'hFFFF, 0);
    #1;
    chkEq("t1_ackW",   32'(AAckA), 1);
    chkEq("t1_ramWr",  32'(ARamWrEn), 32'hFFFF);
    tick();
    setA(1, 0, 8'h10, 16'h0000, 16'h0000, 1);
    #1;
    chkEq("t1_ackR",   32'(AAckA), 1);
    tick();
    setA(1, 0, 8'h20, 16'h1234, 16'hFFFF, 0);
    #1;
    chkEq("t1_vldA",   32'(AVldA), 1);
    chkEq("t1_misoA",  32'(AMisoA), 32'hBEEF);
    chkEq("t1_vldB",   32'(AVldB), 0);
    chkEq("t1_misoB",  32'(AMisoB), 0);
    tick();
    // Combined read+write: low byte takes new data, high byte keeps old.
    setA(1, 0, 8'h10, 16'h0055, 16'h00FF, 1);
    #1;
    chkEq("rmw_ack",   32'(AAckA), 1);
    tick();
    idle();
    #1;
    chkEq("rmw_miso",  32'(AMisoA), 32'hBE55);

    // B locks for a read then a masked write; A waits.
    tick();
    setB(1, 1, 8'h20, 16'h0000, 16'h0000, 1);
    #1;
    chkEq("t3_ackB0",  32'(AAckB), 1);
    tick();
    setA(1, 0, 8'h20, 16'h0000, 16'h0000, 1);
    setB(1, 0, 8'h20, 16'hAAAA, 16'h00FF, 0);
    #1;
    chkEq("t3_ackA_lock", 32'(AAckA), 0);
    chkEq("t3_ackB1",  32'(AAckB), 1);
    chkEq("t3_vldB",   32'(AVldB), 1);
    chkEq("t3_misoB",  32'(AMisoB), 32'h1234);
    tick();
    setB(0, 0, '0, '0, '0, 0);
    #1;
    chkEq("t3_ackA",   32'(AAckA), 1);
    tick();
    idle();
    #1;
    chkEq("t3_misoA",  32'(AMisoA), 32'h12AA);
    tick();

    // Round-robin from reset: A,B,A,B,...
    doReset();
    setA(1, 0, 8'h10, '0, '0, 1);
    setB(1, 0, 8'h20, '0, '0, 1);
    prevA = 1'b0;
    prevB = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chkEq($sformatf("t2_ackA%0d", k), 32'(AAckA), 32'((k % 2) == 0));
      chkEq($sformatf("t2_ackB%0d", k), 32'(AAckB), 32'((k % 2) == 1));
      chkEq($sformatf("t2_misoA%0d", k), 32'(AMisoA), prevA ? 32'hBE55 : 32'h0);
      chkEq($sformatf("t2_misoB%0d", k), 32'(AMisoB), prevB ? 32'h12AA : 32'h0);
      chkEq($sformatf("t2_vldB%0d", k), 32'(AVldB), 32'(prevB));
      prevA = ((k % 2) == 0);
      prevB = ((k % 2) == 1);
      tick();
    end
    idle();
    tick();

    // Lock bound: B keeps ALockB=1 with A requesting.
    setB(1, 1, 8'h20, '0, '0, 1);
    #1;
    bCnt = AAckB ? 1 : 0;
    tick();
    setA(1, 0, 8'h10, '0, '0, 1);
    gotA = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (AAckA) begin
        gotA = 1'b1;
        break;
      end
      if (AAckB) bCnt++;
      tick();
    end
    chkEq("t4_bgrants", 32'(bCnt), 8);
    chkEq("t4_agrant",  32'(gotA), 1);
    tick();
    setB(1, 0, 8'h20, '0, '0, 1);
    #1;
    chkEq("t4_resumeB", 32'(AAckB), 1);
    chkEq("t4_resumeA0", 32'(AAckA), 0);
    tick();
    #1;
    chkEq("t4_rrA",     32'(AAckA), 1);
    tick();
    idle();
    tick();

    // Stall after a granted read.
    setA(1, 0, 8'h10, '0, '0, 1);
    #1;
    chkEq("t5_ack",     32'(AAckA), 1);
    tick();
    AClkHEn = 1'b0;
    setA(1, 0, 8'h10, 16'h0000, 16'hFFFF, 0);
    for (int s = 0; s < 3; s++) begin
      #1;
      chkEq($sformatf("t5_ack%0d", s),  32'(AAckA), 0);
      chkEq($sformatf("t5_wr%0d", s),   32'(ARamWrEn), 0);
      chkEq($sformatf("t5_vld%0d", s),  32'(AVldA), 1);
      chkEq($sformatf("t5_miso%0d", s), 32'(AMisoA), 32'hBE55);
      tick();
    end
    AClkHEn = 1'b1;
    idle();
    tick();
    setA(1, 0, 8'h10, '0, '0, 1);
    tick();
    idle();
    #1;
    chkEq("t5_nowrite", 32'(AMisoA), 32'hBE55);
    tick();

    // Reset during a locked A sequence with a read in flight.
    setA(1, 1, 8'h10, '0, '0, 1);
    #1;
    chkEq("t6_ackA0",   32'(AAckA), 1);
    tick();
    setB(1, 0, 8'h20, '0, '0, 1);
    #1;
    chkEq("t6_ackA1",   32'(AAckA), 1);
    chkEq("t6_ackB_lock", 32'(AAckB), 0);
    tick();
    #1;
    chkEq("t6_vldPre",  32'(AVldA), 1);
    AResetN = 1'b0;
    idle();
    #1;
    chkEq("t6_vldRst",  32'(AVldA), 0);
    chkEq("t6_misoRst", 32'(AMisoA), 0);
    tick();
    AResetN = 1'b1;
    setB(1, 0, 8'h20, '0, '0, 1);
    #1;
    chkEq("t6_ackB",    32'(AAckB), 1);
    tick();
    setA(1, 0, 8'h10, '0, '0, 1);
    #1;
    chkEq("t6_bothA",   32'(AAckA), 1);
    chkEq("t6_bothB",   32'(AAckB), 0);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
